// File: rtl/seq_pkg.sv
// Shared definitions for the register sequencer: opcodes, FSM states,
// opcode classes and instruction field layout helpers.
package seq_pkg;

   localparam int OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LDI = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_MOV = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_AND = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_OR  = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_XOR = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_NOT = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_SHL = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_SHR = 4'hA;
   localparam logic [OPCODE_W-1:0] OP_FIRST_ILLEGAL = 4'hB;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RDA  = 3'd1,
      ST_RDB  = 3'd2,
      ST_CAPB = 3'd3,
      ST_WR   = 3'd4
   } seq_state_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_LDI    = 2'd1,
      CLS_UNARY  = 2'd2,
      CLS_BINARY = 2'd3
   } op_class_t;

   // Instruction layout, MSB first: opcode | dst | srcA | srcB
   function automatic int opcode_lsb(input int addr_w);
      return 3 * addr_w;
   endfunction

   function automatic int dst_lsb(input int addr_w);
      return 2 * addr_w;
   endfunction

   function automatic int src_a_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int src_b_lsb(input int addr_w);
      return 0 * addr_w;
   endfunction

   function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
      op_class_t cls;
      case (op)
         OP_LDI:                                 cls = CLS_LDI;
         OP_MOV, OP_NOT, OP_SHL, OP_SHR:         cls = CLS_UNARY;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  cls = CLS_BINARY;
         default:                                cls = CLS_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/sequencer_alu.sv
// Combinational 8-bit ALU for the register sequencer; carry is the
// carry-out, borrow, or shifted-out bit depending on the opcode.
module sequencer_alu
   import seq_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [DATA_W-1:0]   op_a,
   input  logic [DATA_W-1:0]   op_b,
   input  logic [DATA_W-1:0]   imm,
   output logic [DATA_W-1:0]   result,
   output logic                carry
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, op_a} + {1'b0, op_b};
   assign diff = {1'b0, op_a} - {1'b0, op_b};

   // diff[DATA_W] is the borrow, set exactly when op_a < op_b unsigned
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (opcode)
         OP_LDI: result = imm;
         OP_MOV: result = op_a;
         OP_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
         end
         OP_SUB: begin
            result = diff[DATA_W-1:0];
            carry  = diff[DATA_W];
         end
         OP_AND: result = op_a & op_b;
         OP_OR:  result = op_a | op_b;
         OP_XOR: result = op_a ^ op_b;
         OP_NOT: result = ~op_a;
         OP_SHL: begin
            result = {op_a[DATA_W-2:0], 1'b0};
            carry  = op_a[DATA_W-1];
         end
         OP_SHR: begin
            result = {1'b0, op_a[DATA_W-1:1]};
            carry  = op_a[0];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/register_sequencer.sv
// Three-address instruction sequencer driving a 16x8 register unit:
// fetches operands over the load port, computes, and writes back.
module register_sequencer
   import seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [OPCODE_W+3*ADDR_W-1:0]   instr,
   input  logic                           instr_valid,
   output logic                           instr_ready,
   output logic                           reg_load,
   output logic                           reg_store,
   output logic [ADDR_W-1:0]              reg_load_addr,
   output logic [ADDR_W-1:0]              reg_store_addr,
   output logic [DATA_W-1:0]              reg_wdata,
   input  logic [DATA_W-1:0]              reg_rdata,
   output logic                           done,
   output logic                           flag_z,
   output logic                           flag_c,
   output logic                           illegal
);

   seq_state_t          state;
   op_class_t           class_q;
   logic [OPCODE_W-1:0] opcode_q;
   logic [ADDR_W-1:0]   dst_q;
   logic [ADDR_W-1:0]   src_b_q;
   logic [DATA_W-1:0]   op_a_q;
   logic [DATA_W-1:0]   op_b_q;
   logic                wr_carry;

   logic [OPCODE_W-1:0] in_opcode;
   logic [ADDR_W-1:0]   in_dst;
   logic [ADDR_W-1:0]   in_src_a;
   logic [ADDR_W-1:0]   in_src_b;
   logic [DATA_W-1:0]   in_imm;
   op_class_t           in_class;

   assign in_opcode = instr[opcode_lsb(ADDR_W) +: OPCODE_W];
   assign in_dst    = instr[dst_lsb(ADDR_W)    +: ADDR_W];
   assign in_src_a  = instr[src_a_lsb(ADDR_W)  +: ADDR_W];
   assign in_src_b  = instr[src_b_lsb(ADDR_W)  +: ADDR_W];
   assign in_imm    = instr[DATA_W-1:0];
   assign in_class  = classify(in_opcode);

   // Operands arriving this cycle bypass their latches so the result
   // can be registered on the same edge that enters write-back.
   logic [OPCODE_W-1:0] alu_opcode;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry;

   assign alu_opcode = (state == ST_IDLE) ? in_opcode : opcode_q;
   assign alu_a      = (state == ST_RDB)  ? reg_rdata : op_a_q;
   assign alu_b      = (state == ST_CAPB) ? reg_rdata : op_b_q;

   sequencer_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .opcode (alu_opcode),
      .op_a   (alu_a),
      .op_b   (alu_b),
      .imm    (in_imm),
      .result (alu_result),
      .carry  (alu_carry)
   );

   logic enter_wr;

   always_comb begin
      enter_wr = 1'b0;
      case (state)
         ST_IDLE: enter_wr = instr_valid && (in_class == CLS_LDI);
         ST_RDB:  enter_wr = (class_q == CLS_UNARY);
         ST_CAPB: enter_wr = 1'b1;
         default: enter_wr = 1'b0;
      endcase
   end

   // Strobes, addresses and data default to zero each cycle so they are
   // only non-zero while their strobe is asserted.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         class_q        <= CLS_NONE;
         opcode_q       <= OP_NOP;
         dst_q          <= '0;
         src_b_q        <= '0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         wr_carry       <= 1'b0;
         instr_ready    <= 1'b1;
         reg_load       <= 1'b0;
         reg_store      <= 1'b0;
         reg_load_addr  <= '0;
         reg_store_addr <= '0;
         reg_wdata      <= '0;
         done           <= 1'b0;
         flag_z         <= 1'b0;
         flag_c         <= 1'b0;
         illegal        <= 1'b0;
      end else begin
         reg_load       <= 1'b0;
         reg_load_addr  <= '0;
         reg_store      <= 1'b0;
         reg_store_addr <= '0;
         reg_wdata      <= '0;
         done           <= 1'b0;
         illegal        <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (instr_valid) begin
                  opcode_q <= in_opcode;
                  dst_q    <= in_dst;
                  src_b_q  <= in_src_b;
                  class_q  <= in_class;
                  case (in_class)
                     CLS_BINARY, CLS_UNARY: begin
                        state         <= ST_RDA;
                        instr_ready   <= 1'b0;
                        reg_load      <= 1'b1;
                        reg_load_addr <= in_src_a;
                     end
                     CLS_LDI: begin
                        state       <= ST_WR;
                        instr_ready <= 1'b0;
                     end
                     default: illegal <= (in_opcode >= OP_FIRST_ILLEGAL);
                  endcase
               end
            end
            ST_RDA: begin
               state <= ST_RDB;
               if (class_q == CLS_BINARY) begin
                  reg_load      <= 1'b1;
                  reg_load_addr <= src_b_q;
               end
            end
            ST_RDB: begin
               op_a_q <= reg_rdata;
               state  <= (class_q == CLS_BINARY) ? ST_CAPB : ST_WR;
            end
            ST_CAPB: begin
               op_b_q <= reg_rdata;
               state  <= ST_WR;
            end
            ST_WR: begin
               flag_z      <= (reg_wdata == '0);
               flag_c      <= wr_carry;
               state       <= ST_IDLE;
               instr_ready <= 1'b1;
            end
            default: begin
               state       <= ST_IDLE;
               instr_ready <= 1'b1;
            end
         endcase

         if (enter_wr) begin
            reg_store      <= 1'b1;
            reg_store_addr <= (state == ST_IDLE) ? in_dst : dst_q;
            reg_wdata      <= alu_result;
            wr_carry       <= alu_carry;
            done           <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_register_sequencer.sv
// Directed bench for register_sequencer with a behavioural 16x8 register
// unit attached to its load/store ports.
module tb_register_sequencer;

   logic        clock;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        reg_load;
   logic        reg_store;
   logic [3:0]  reg_load_addr;
   logic [3:0]  reg_store_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata;
   logic        done;
   logic        flag_z;
   logic        flag_c;
   logic        illegal;

   int checks = 0;
   int passes = 0;
   int mon_errors = 0;
   int store_count = 0;
   int accept_count = 0;
   logic [3:0] last_st_addr = '0;

   logic [7:0] rf [0:15];

   register_sequencer #(
      .DATA_W (8),
      .ADDR_W (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .reg_load       (reg_load),
      .reg_store      (reg_store),
      .reg_load_addr  (reg_load_addr),
      .reg_store_addr (reg_store_addr),
      .reg_wdata      (reg_wdata),
      .reg_rdata      (reg_rdata),
      .done           (done),
      .flag_z         (flag_z),
      .flag_c         (flag_c),
      .illegal        (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Register unit: registered read, load has priority over store
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
         reg_rdata <= 8'h00;
      end else if (reg_load) begin
         reg_rdata <= rf[reg_load_addr];
      end else if (reg_store) begin
         rf[reg_store_addr] <= reg_wdata;
      end
   end

   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (reg_load && reg_store) begin
            mon_errors++;
            $display("[TB] FAIL protocol load_and_store both high at %0t", $time);
         end
         if (!reg_load && reg_load_addr !== 4'h0) begin
            mon_errors++;
            $display("[TB] FAIL protocol load_addr got %h want 0 at %0t", reg_load_addr, $time);
         end
         if (!reg_store && (reg_store_addr !== 4'h0 || reg_wdata !== 8'h00)) begin
            mon_errors++;
            $display("[TB] FAIL protocol store addr/data got %h/%h want 0 at %0t", reg_store_addr, reg_wdata, $time);
         end
         if (reg_store) begin
            store_count++;
            last_st_addr = reg_store_addr;
         end
         if (instr_valid && instr_ready) accept_count++;
      end
   end

   // Presents one instruction from the #1-after-edge phase, returns the
   // cycle (accept cycle = 0) in which done is seen, or 0 if never.
   task automatic issue(input logic [15:0] ins, output int lat);
      int guard;
      lat = 0;
      guard = 0;
      instr = ins;
      instr_valid = 1'b1;
      while (!instr_ready && guard < 50) begin
         @(posedge clock); #1;
         guard++;
      end
      @(posedge clock); #1;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      for (int n = 1; n <= 8; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      instr = 16'h1F11;
      instr_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", instr_ready); else passes++;
      checks++; if ({reg_load, reg_store, reg_load_addr, reg_store_addr, reg_wdata} !== 18'h0)
         $display("[TB] FAIL reset_regport got %h want 0", {reg_load, reg_store, reg_load_addr, reg_store_addr, reg_wdata}); else passes++;
      checks++; if ({done, illegal} !== 2'b00) $display("[TB] FAIL reset_pulses got %b want 00", {done, illegal}); else passes++;
      checks++; if ({flag_z, flag_c} !== 2'b00) $display("[TB] FAIL reset_flags got %b want 00", {flag_z, flag_c}); else passes++;
      instr_valid = 1'b0;
      reset = 1'b0;
      @(posedge clock); #1;
      checks++; if ({instr_ready, reg_store, done} !== 3'b100) $display("[TB] FAIL reset_wins got %b want 100", {instr_ready, reg_store, done}); else passes++;
   endtask

   task automatic test_add();
      int lat;
      issue(16'h135A, lat);
      checks++; if (lat !== 1) $display("[TB] FAIL ldi_latency got %0d want 1", lat); else passes++;
      checks++; if (rf[3] !== 8'h5A) $display("[TB] FAIL ldi_r3 got %h want 5a", rf[3]); else passes++;
      issue(16'h14A6, lat);
      checks++; if (rf[4] !== 8'hA6) $display("[TB] FAIL ldi_r4 got %h want a6", rf[4]); else passes++;
      issue(16'h3534, lat);
      checks++; if (lat !== 4) $display("[TB] FAIL add_latency got %0d want 4", lat); else passes++;
      checks++; if (rf[5] !== 8'h00) $display("[TB] FAIL add_result got %h want 00", rf[5]); else passes++;
      checks++; if (last_st_addr !== 4'h5) $display("[TB] FAIL add_dst got %h want 5", last_st_addr); else passes++;
      checks++; if ({flag_z, flag_c} !== 2'b11) $display("[TB] FAIL add_flags got %b want 11", {flag_z, flag_c}); else passes++;
   endtask

   task automatic test_illegal();
      int sc0;
      sc0 = store_count;
      instr = 16'hC123;
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      checks++; if (illegal !== 1'b1) $display("[TB] FAIL illegal_pulse got %b want 1", illegal); else passes++;
      checks++; if ({instr_ready, reg_load, reg_store} !== 3'b100) $display("[TB] FAIL illegal_ports got %b want 100", {instr_ready, reg_load, reg_store}); else passes++;
      @(posedge clock); #1;
      checks++; if (illegal !== 1'b0) $display("[TB] FAIL illegal_once got %b want 0", illegal); else passes++;
      checks++; if ({flag_z, flag_c} !== 2'b11) $display("[TB] FAIL illegal_flags got %b want 11", {flag_z, flag_c}); else passes++;
      checks++; if (store_count !== sc0) $display("[TB] FAIL illegal_store got %0d want %0d", store_count, sc0); else passes++;
   endtask

   task automatic test_sub_shr();
      int lat;
      issue(16'h1103, lat);
      issue(16'h1205, lat);
      issue(16'h4612, lat);
      checks++; if (rf[6] !== 8'hFE) $display("[TB] FAIL sub_result got %h want fe", rf[6]); else passes++;
      checks++; if ({flag_z, flag_c} !== 2'b01) $display("[TB] FAIL sub_flags got %b want 01", {flag_z, flag_c}); else passes++;
      issue(16'hA760, lat);
      checks++; if (lat !== 3) $display("[TB] FAIL shr_latency got %0d want 3", lat); else passes++;
      checks++; if (rf[7] !== 8'h7F) $display("[TB] FAIL shr_result got %h want 7f", rf[7]); else passes++;
      checks++; if ({flag_z, flag_c} !== 2'b00) $display("[TB] FAIL shr_flags got %b want 00", {flag_z, flag_c}); else passes++;
   endtask

   task automatic test_xor();
      int lat;
      issue(16'h12FF, lat);
      issue(16'h7222, lat);
      checks++; if (lat !== 4) $display("[TB] FAIL xor_latency got %0d want 4", lat); else passes++;
      checks++; if (rf[2] !== 8'h00) $display("[TB] FAIL xor_result got %h want 00", rf[2]); else passes++;
      checks++; if ({flag_z, flag_c} !== 2'b10) $display("[TB] FAIL xor_flags got %b want 10", {flag_z, flag_c}); else passes++;
   endtask

   task automatic test_reset_mid();
      int sc0;
      int lat;
      sc0 = store_count;
      instr = 16'h3534;
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      checks++; if ({reg_load, reg_store, reg_load_addr, reg_store_addr, reg_wdata, done} !== 19'h0)
         $display("[TB] FAIL midreset_ports got %h want 0", {reg_load, reg_store, reg_load_addr, reg_store_addr, reg_wdata, done}); else passes++;
      checks++; if ({instr_ready, flag_z, flag_c} !== 3'b100) $display("[TB] FAIL midreset_state got %b want 100", {instr_ready, flag_z, flag_c}); else passes++;
      reset = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      checks++; if (store_count !== sc0) $display("[TB] FAIL midreset_nostore got %0d want %0d", store_count, sc0); else passes++;
      issue(16'h1942, lat);
      checks++; if (lat !== 1) $display("[TB] FAIL midreset_ldi_latency got %0d want 1", lat); else passes++;
      checks++; if (rf[9] !== 8'h42) $display("[TB] FAIL midreset_ldi got %h want 42", rf[9]); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] prog [4];
      int acc [4];
      int k;
      int cyc;
      int ac0;
      prog[0] = 16'h1110;
      prog[1] = 16'h1220;
      prog[2] = 16'h3312;
      prog[3] = 16'h4431;
      for (int i = 0; i < 4; i++) acc[i] = 0;
      k = 0;
      cyc = 0;
      ac0 = accept_count;
      instr = prog[0];
      instr_valid = 1'b1;
      while (k < 4 && cyc < 200) begin
         if (instr_ready) begin
            acc[k] = cyc;
            k++;
         end
         @(posedge clock); #1;
         if (k == 4) instr_valid = 1'b0;
         else instr = prog[k];
         cyc++;
      end
      instr_valid = 1'b0;
      for (int n = 0; n < 10 && !done; n++) begin
         @(posedge clock); #1;
      end
      @(posedge clock); #1;
      checks++; if (accept_count - ac0 !== 4) $display("[TB] FAIL b2b_accepts got %0d want 4", accept_count - ac0); else passes++;
      checks++; if ({acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]} !== {32'd2, 32'd2, 32'd5})
         $display("[TB] FAIL b2b_spacing got %0d,%0d,%0d want 2,2,5", acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]); else passes++;
      checks++; if ({rf[3], rf[4]} !== 16'h3020) $display("[TB] FAIL b2b_results got %h want 3020", {rf[3], rf[4]}); else passes++;
      checks++; if ({flag_z, flag_c} !== 2'b00) $display("[TB] FAIL b2b_flags got %b want 00", {flag_z, flag_c}); else passes++;
   endtask

   task automatic test_protocol();
      checks++; if (mon_errors !== 0) $display("[TB] FAIL protocol_total got %0d want 0", mon_errors); else passes++;
   endtask

   initial begin
      reset = 1'b1;
      instr = 16'h0000;
      instr_valid = 1'b0;
      test_reset();
      test_add();
      test_illegal();
      test_sub_shr();
      test_xor();
      test_reset_mid();
      test_back_to_back();
      test_protocol();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
